// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider: operands/start in, ready/done/results out.
interface seq_divider_if #(
   parameter int N = 4
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         ready;
   logic         done;
   logic [N-1:0] q;
   logic [N-1:0] r;
   logic         dbz;

   modport master (output start, a, b, input ready, done, q, r, dbz);
   modport slave  (input start, a, b, output ready, done, q, r, dbz);
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Optional feature macro: SEQ_DIVIDER_DBZ_EN (early divide-by-zero completion with dbz flag).
module seq_divider #(
   parameter int N = 4
) (
   input  logic          clk,
   input  logic          rst,
   seq_divider_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = $clog2(N);

   state_t       state_r;
   state_t       next_state_s;
   logic [N-1:0] work_r;
   logic [N-1:0] dvs_r;
   logic [N-1:0] rem_r;
   logic [CW-1:0] cnt_r;
   logic [N-1:0] q_r;
   logic [N-1:0] r_r;
   logic         dbz_r;

   logic [N:0]   shifted_s;
   logic [N-1:0] trial_s;
   logic [N-1:0] rem_next_s;
   logic         qbit_s;
   logic         zero_div_s;

`ifdef SEQ_DIVIDER_DBZ_EN
   assign zero_div_s = (bus.b == {N{1'b0}});
`else
   assign zero_div_s = 1'b0;
`endif

   assign bus.ready = (state_r == IDLE);
   assign bus.done  = (state_r == DONE);
   assign bus.q     = q_r;
   assign bus.r     = r_r;
   assign bus.dbz   = dbz_r;

   // One restoring step; a successful subtract always yields a value below b, so N bits suffice.
   always_comb begin
      shifted_s = {1'b0, rem_r, work_r[N-1]} >> 1;
      shifted_s = {rem_r, work_r[N-1]};
      trial_s   = shifted_s[N-1:0] - dvs_r;
      qbit_s    = (shifted_s >= {1'b0, dvs_r});
      if (qbit_s) begin
         rem_next_s = trial_s;
      end else begin
         rem_next_s = shifted_s[N-1:0];
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               if (zero_div_s) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = RUN;
               end
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == {CW{1'b0}}) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Datapath: the dividend register empties from the top while quotient bits fill it from the bottom.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_r <= {N{1'b0}};
         dvs_r  <= {N{1'b0}};
         rem_r  <= {N{1'b0}};
         cnt_r  <= {CW{1'b0}};
         q_r    <= {N{1'b0}};
         r_r    <= {N{1'b0}};
         dbz_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  work_r <= bus.a;
                  dvs_r  <= bus.b;
                  rem_r  <= {N{1'b0}};
                  cnt_r  <= CW'(N - 1);
                  if (zero_div_s) begin
                     q_r   <= {N{1'b1}};
                     r_r   <= bus.a;
                     dbz_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               work_r <= {work_r[N-2:0], qbit_s};
               rem_r  <= rem_next_s;
               if (cnt_r == {CW{1'b0}}) begin
                  q_r   <= {work_r[N-2:0], qbit_s};
                  r_r   <= rem_next_s;
                  dbz_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider checked against an arithmetic reference model.
module tb_seq_divider;
   localparam int N = 4;
`ifdef SEQ_DIVIDER_DBZ_EN
   localparam bit DBZ_EN = 1'b1;
`else
   localparam bit DBZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_divider_if #(.N(N)) bus();
   seq_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: cycles remaining until completion, plus the results that will appear then.
   int           m_left;
   bit           m_done;
   logic [N-1:0] m_q, m_r, p_q, p_r;
   bit           m_dbz, p_dbz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_done = 0; m_q = '0; m_r = '0; m_dbz = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_dbz;
         end
      end else if (bus.start) begin
         if (bus.b == 0) begin
            p_q = '1; p_r = bus.a;
         end else begin
            p_q = bus.a / bus.b; p_r = bus.a % bus.b;
         end
         p_dbz = DBZ_EN && (bus.b == 0);
         if (p_dbz) begin
            m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 1;
         end else begin
            m_left = N;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("ready", bus.ready, (!m_done && m_left == 0));
         chk("done",  bus.done,  m_done);
         chk("q",     bus.q,     m_q);
         chk("r",     bus.r,     m_r);
         chk("dbz",   bus.dbz,   m_dbz);
      end
   end

   task automatic run(input int av, input int bv, input bit intrude, output int lat);
      int guard = 0;
      while (!bus.ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_wait", bus.ready, 1);
      bus.a = av[N-1:0]; bus.b = bv[N-1:0]; bus.start = 1'b1;
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         bus.start = 1'b0;
         if (intrude && lat == 2) begin
            bus.start = 1'b1; bus.a = 4'd6; bus.b = 4'd2;
         end
         if (bus.done) break;
      end
      if (!bus.done) lat = 99;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat, cnt;
      rst = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
      #1 rst = 1'b1;
      #1;
      chk("rst_q", bus.q, 0); chk("rst_r", bus.r, 0); chk("rst_done", bus.done, 0);
      chk("rst_ready", bus.ready, 1); chk("rst_dbz", bus.dbz, 0);
      @(negedge clk) rst = 1'b0;

      run(13, 3, 0, lat);
      chk("t1_lat", lat, 5); chk("t1_q", bus.q, 4); chk("t1_r", bus.r, 1); chk("t1_dbz", bus.dbz, 0);
      repeat (3) @(negedge clk);
      chk("t1_hold_q", bus.q, 4); chk("t1_hold_r", bus.r, 1);

      run(15, 1, 0, lat); chk("b2b1_q", bus.q, 15); chk("b2b1_r", bus.r, 0); chk("b2b1_lat", lat, 5);
      run(2, 7, 0, lat);  chk("b2b2_q", bus.q, 0);  chk("b2b2_r", bus.r, 2); chk("b2b2_lat", lat, 5);
      run(0, 5, 0, lat);  chk("b2b3_q", bus.q, 0);  chk("b2b3_r", bus.r, 0); chk("b2b3_lat", lat, 5);

      run(9, 0, 0, lat);
      chk("dbz_lat", lat, DBZ_EN ? 1 : 5); chk("dbz_q", bus.q, 15); chk("dbz_r", bus.r, 9);
      chk("dbz_flag", bus.dbz, DBZ_EN ? 1 : 0);

      run(11, 4, 1, lat);
      chk("ign_lat", lat, 5); chk("ign_q", bus.q, 2); chk("ign_r", bus.r, 3);
      cnt = 0;
      repeat (8) begin @(negedge clk); if (bus.done) cnt++; end
      chk("ign_extra_done", cnt, 0);

      @(negedge clk);
      bus.a = 4'd13; bus.b = 4'd3; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk) bus.start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_q", bus.q, 0); chk("arst_r", bus.r, 0); chk("arst_done", bus.done, 0);
      chk("arst_ready", bus.ready, 1);
      @(negedge clk) rst = 1'b0;
      cnt = 0;
      repeat (8) begin @(negedge clk); if (bus.done) cnt++; end
      chk("arst_no_done", cnt, 0);
      run(7, 2, 0, lat); chk("arst_new_q", bus.q, 3); chk("arst_new_r", bus.r, 1);

      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 1; bi < 16; bi++) begin
            run(ai, bi, 0, lat);
            chk("exh_lat", lat, 5); chk("exh_q", bus.q, ai / bi); chk("exh_r", bus.r, ai % bi);
         end
      end

      for (int k = 0; k < 200; k++) begin
         int ra, rb;
         ra = $urandom_range(0, 15);
         rb = $urandom_range(0, 15);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run(ra, rb, 0, lat);
         if (rb == 0) begin
            chk("rnd_lat0", lat, DBZ_EN ? 1 : 5); chk("rnd_q0", bus.q, 15); chk("rnd_r0", bus.r, ra);
         end else begin
            chk("rnd_lat", lat, 5); chk("rnd_q", bus.q, ra / rb); chk("rnd_r", bus.r, ra % rb);
         end
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
